serial_pattern_tx: RTL and testbench

Serial stimulus transmitter: latches a parallel bit pattern and shifts it out one bit per clock on a single serial line `w`, optionally repeating it with a one-cycle idle gap between copies. It is the driving end of the serial `w` input used by the Moore-machine sequence detectors in the FSM library. It replaces hand-written delay-based stimulus with a synthesizable, cycle-exact source. Status outputs are Moore outputs of its own state machine.

---
 rtl/serial_pattern_pkg.sv | 14 +
 rtl/pattern_shift_reg.sv | 31 +++
 rtl/serial_pattern_tx.sv | 93 +++++++++
 tb/tb_serial_pattern_tx.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/serial_pattern_pkg.sv
// Shared state encoding for the serial pattern transmitter.
// State codes are visible on the `state` port, so values are fixed.
package serial_pattern_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/pattern_shift_reg.sv
// Loadable bidirectional shift register presenting one serial bit per clock.
// Latency: load visible next cycle; no backpressure, load has priority over shift.
module pattern_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             load,
  input  logic             shift,
  input  logic             msb_first,
  input  logic [WIDTH-1:0] data,
  output logic             ser_bit
);

  logic [WIDTH-1:0] sr;

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      sr <= '0;
    end else if (load) begin
      sr <= data;
    end else if (shift) begin
      // Move the next bit toward whichever end is being presented.
      if (msb_first) sr <= {sr[WIDTH-2:0], 1'b0};
      else           sr <= {1'b0, sr[WIDTH-1:1]};
    end
  end

  assign ser_bit = msb_first ? sr[WIDTH-1] : sr[0];

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: first bit on w one cycle after start, optional repeats with 1-cycle gap.
// No backpressure: start is only sampled in IDLE and never queued.
module serial_pattern_tx
  import serial_pattern_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic               Clock,
  input  logic               Resetn,
  input  logic               start,
  input  logic [WIDTH-1:0]   pattern,
  input  logic               msb_first,
  input  logic [CNT_W-1:0]   repeat_n,
  output logic               w,
  output logic               busy,
  output logic               done,
  output logic [STATE_W-1:0] state
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

  state_e           st;
  logic [BW-1:0]    bitcnt;
  logic [CNT_W-1:0] rptcnt;
  logic [WIDTH-1:0] pat_q;
  logic             msb_q;
  logic             sr_load;
  logic [WIDTH-1:0] sr_data;
  logic             ser_bit;

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      st     <= IDLE;
      bitcnt <= '0;
      rptcnt <= '0;
      pat_q  <= '0;
      msb_q  <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          if (start) begin
            pat_q  <= pattern;
            msb_q  <= msb_first;
            rptcnt <= repeat_n;
            bitcnt <= LAST;
            st     <= SEND;
          end
        end
        SEND: begin
          if (bitcnt == '0) begin
            if (rptcnt != '0) begin
              rptcnt <= rptcnt - CNT_W'(1);
              st     <= GAP;
            end else begin
              st     <= DONE;
            end
          end else begin
            bitcnt <= bitcnt - BW'(1);
          end
        end
        GAP: begin
          bitcnt <= LAST;
          st     <= SEND;
        end
        default: st <= IDLE;
      endcase
    end
  end

  // A fresh copy is loaded on acceptance and again during every gap cycle.
  assign sr_load = ((st == IDLE) && start) || (st == GAP);
  assign sr_data = (st == GAP) ? pat_q : pattern;

  pattern_shift_reg #(
    .WIDTH(WIDTH)
  ) u_sr (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .load      (sr_load),
    .shift     (st == SEND),
    .msb_first (msb_q),
    .data      (sr_data),
    .ser_bit   (ser_bit)
  );

  assign w     = (st == SEND) && ser_bit;
  assign busy  = (st == SEND) || (st == GAP);
  assign done  = (st == DONE);
  assign state = st;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx: table of streams plus reset and start-while-busy sequences.
module tb_serial_pattern_tx;

  logic       Clock;
  logic       Resetn;
  logic       start;
  logic [7:0] pattern;
  logic       msb_first;
  logic [3:0] repeat_n;
  logic       w;
  logic       busy;
  logic       done;
  logic [1:0] state;

  int n_cmp = 0;
  int n_err = 0;

  serial_pattern_tx #(
    .WIDTH(8),
    .CNT_W(4)
  ) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .start     (start),
    .pattern   (pattern),
    .msb_first (msb_first),
    .repeat_n  (repeat_n),
    .w         (w),
    .busy      (busy),
    .done      (done),
    .state     (state)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [7:0]  pattern;
    logic        msb;
    logic [3:0]  rpt;
    logic [31:0] exp_w;   // bit c = required w in busy cycle c
    logic [31:0] gap;     // bit c set where state must be GAP
    int          len;     // busy cycles
    int          poke;    // busy cycle in which a stray start is pulsed, -1 for none
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string name);
    check({name, ".w"},     32'(w),     32'd0);
    check({name, ".busy"},  32'(busy),  32'd0);
    check({name, ".done"},  32'(done),  32'd0);
    check({name, ".state"}, 32'(state), 32'd0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    pattern   = v.pattern;
    msb_first = v.msb;
    repeat_n  = v.rpt;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    // Scramble inputs after capture; they must not matter.
    pattern   = ~v.pattern;
    msb_first = ~v.msb;
    repeat_n  = v.rpt + 4'd3;
    for (int c = 0; c < v.len; c++) begin
      check($sformatf("%s.c%0d.w", tag, c), 32'(w), 32'(v.exp_w[c]));
      check($sformatf("%s.c%0d.busy", tag, c), 32'(busy), 32'd1);
      check($sformatf("%s.c%0d.state", tag, c), 32'(state), v.gap[c] ? 32'd2 : 32'd1);
      if (c == v.poke) begin
        start   = 1'b1;
        pattern = 8'hFF;
      end else begin
        start   = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    check({tag, ".done"},       32'(done),  32'd1);
    check({tag, ".done_busy"},  32'(busy),  32'd0);
    check({tag, ".done_w"},     32'(w),     32'd0);
    check({tag, ".done_state"}, 32'(state), 32'd3);
    tick();
    for (int i = 0; i < 3; i++) begin
      check_idle($sformatf("%s.idle%0d", tag, i));
      tick();
    end
  endtask

  initial begin
    vecs[0] = '{8'b1011_0010, 1'b0, 4'd0, 32'h0000_00B2, 32'h0, 8, -1};
    vecs[1] = '{8'b1011_0010, 1'b1, 4'd0, 32'h0000_004D, 32'h0, 8, -1};
    vecs[2] = '{8'hA5, 1'b0, 4'd2, {6'b0, 8'hA5, 1'b0, 8'hA5, 1'b0, 8'hA5}, 32'h0002_0100, 26, -1};
    vecs[3] = '{8'h0F, 1'b1, 4'd1, {15'b0, 8'hF0, 1'b0, 8'hF0}, 32'h0000_0100, 17, -1};
    vecs[4] = '{8'h01, 1'b0, 4'd0, 32'h0000_0001, 32'h0, 8, -1};
    vecs[5] = '{8'h0F, 1'b0, 4'd0, 32'h0000_000F, 32'h0, 8, 3};

    Resetn    = 1'b0;
    start     = 1'b1;
    pattern   = 8'hFF;
    msb_first = 1'b0;
    repeat_n  = 4'd0;
    tick();
    check_idle("rst0");
    tick();
    check_idle("rst1");
    start  = 1'b0;
    Resetn = 1'b1;
    tick();
    check_idle("rst_release");

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Reset while bit 4 of a transmission is on the line.
    pattern   = 8'b1011_0010;
    msb_first = 1'b0;
    repeat_n  = 4'd1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    check("midrst.bit4_w", 32'(w), 32'd1);
    Resetn = 1'b0;
    tick();
    check_idle("midrst.after");
    Resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle($sformatf("midrst.quiet%0d", i));
    end
    run_vec(6, vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
